// File: rtl/input_debouncer_pkg.sv
// Shared types and constants for the input debouncer slice.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_t;

    localparam int unsigned DEB_SYNC_STAGES = 2;

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between the raw input source and the debouncer.
interface input_debouncer_if;
    import debounce_pkg::*;

    logic din;
    logic dout;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    modport master (
        output din,
        input  dout,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    modport slave (
        input  din,
        output dout,
        output rise_pulse,
        output fall_pulse,
        output busy
    );
endinterface

// File: rtl/input_debouncer_sync.sv
// Two-flop synchronizer for an asynchronous level input.
module sync_2ff
    import debounce_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic s1;

    // Shift the raw input through two flops to resolve metastability.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/input_debouncer.sv
// Debouncer: synchronizes a bouncy input, qualifies each level change over
// STABLE_CYCLES synced samples and emits registered edge pulses.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input_debouncer_if.slave   bus
);
    if (STABLE_CYCLES < 2) begin : g_param_check
        $fatal(1, "input_debouncer: STABLE_CYCLES must be at least 2");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s2;
    deb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dout_r, dout_nxt;
    logic             rise_r, rise_nxt;
    logic             fall_r, fall_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.din),
        .q     (s2)
    );

    // Next-state: count consecutive synced samples that disagree with dout.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        dout_nxt  = dout_r;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        unique case (state)
            IDLE_LOW: begin
                if (s2) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_nxt = IDLE_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HIGH;
                    dout_nxt  = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_nxt = IDLE_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    dout_nxt  = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
            end
        endcase
    end

    // Register FSM state, qualification counter, level and pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE_LOW;
            cnt    <= '0;
            dout_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dout_r <= dout_nxt;
            rise_r <= rise_nxt;
            fall_r <= fall_nxt;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.rise_pulse = rise_r;
    assign bus.fall_pulse = fall_r;
    assign bus.busy       = (state == WAIT_HIGH) || (state == WAIT_LOW);
endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer with STABLE_CYCLES=4.
module tb_input_debouncer;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    input_debouncer_if bus ();

    input_debouncer #(.STABLE_CYCLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: two-sample input delay, then a run length of samples that
    // differ from the accepted level; N in a row flips the level.
    logic m_s1, m_s2, m_dout, m_rise, m_fall;
    int   m_run;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_dout = 0; m_rise = 0; m_fall = 0; m_run = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (m_s2 != m_dout) begin
                m_run++;
                if (m_run == N) begin
                    m_dout = ~m_dout;
                    if (m_dout) m_rise = 1; else m_fall = 1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = bus.din;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("dout", bus.dout, m_dout);
        check("rise_pulse", bus.rise_pulse, m_rise);
        check("fall_pulse", bus.fall_pulse, m_fall);
        check("busy", bus.busy, m_run != 0);
        check("pulse_exclusive", bus.rise_pulse & bus.fall_pulse, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, bus.dout, 1'b0);
        check({tag, "_rise"}, bus.rise_pulse, 1'b0);
        check({tag, "_fall"}, bus.fall_pulse, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    int rises;
    int hold;
    logic [5:0] pat;

    initial begin
        bus.din = 1'b0;
        model_reset();
        #2;
        check_all_zero("reset");
        ticks(2);
        @(negedge clk);
        reset = 1'b0;
        ticks(3);

        // Clean rise: din goes high before edge 0 and is held.
        bus.din = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("rise_dout_t", bus.dout, e >= 5);
            check("rise_pulse_t", bus.rise_pulse, e == 5);
            check("rise_busy_t", bus.busy, e >= 2 && e <= 4);
        end

        // Clean fall from dout=1.
        bus.din = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("fall_dout_t", bus.dout, e < 5);
            check("fall_pulse_t", bus.fall_pulse, e == 5);
            check("fall_norise_t", bus.rise_pulse, 1'b0);
        end

        // Bounce reject: high for 3 cycles only.
        rises = 0;
        bus.din = 1'b1;
        for (int e = 0; e < 3; e++) begin tick(); rises += int'(bus.rise_pulse); end
        bus.din = 1'b0;
        for (int e = 0; e < 8; e++) begin tick(); rises += int'(bus.rise_pulse); end
        check("bounce_dout", bus.dout, 1'b0);
        check("bounce_busy", bus.busy, 1'b0);
        check("bounce_no_rise", rises == 0, 1'b1);

        // Bounce then settle: 1,0,1,1,0 then final 1 held.
        pat = 6'b101101;
        for (int i = 5; i >= 1; i--) begin bus.din = pat[i]; tick(); end
        bus.din = 1'b1;
        rises = 0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            rises += int'(bus.rise_pulse);
            check("settle_pulse_t", bus.rise_pulse, e == 5);
        end
        check("settle_one_rise", rises == 1, 1'b1);

        // Reset while dout=1 and din=1: outputs clear immediately, then a full
        // rise qualification runs after release.
        #2 reset = 1'b1;
        model_reset();
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("rel_dout_t", bus.dout, e >= 5);
            check("rel_pulse_t", bus.rise_pulse, e == 5);
        end

        // Return low, then abandon a rise qualification at cnt=2.
        bus.din = 1'b0;
        ticks(8);
        bus.din = 1'b1;
        ticks(4);
        check("midq_busy_before", bus.busy, 1'b1);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all_zero("midq_reset");
        bus.din = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rises = 0;
        for (int e = 0; e < 10; e++) begin tick(); rises += int'(bus.rise_pulse); end
        check("midq_no_rise", rises == 0, 1'b1);

        // Randomized input with mixed hold lengths around the threshold.
        for (int k = 0; k < 120; k++) begin
            bus.din = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 7));
            ticks(hold);
        end
        bus.din = 1'b0;
        ticks(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
